// File: rtl/psum_out_stage.sv
// psum_out_stage
//   Output stage behind the path stage. Accepts one vector of PEROW partial
//   sums (plus its config word) per rdy/ack transfer into a 2-entry buffer.
//   Each element is post-processed (arithmetic right shift with round-half-up,
//   optional ReLU, saturation to OUTDW), and the elements are sent one per
//   transfer onto the output-buffer write bus.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_PS_rdy/o_PS_ack input vector handshake
//   i_Psum_PS         PEROW x PSUMDWD psum vector, element k at [k*PSUMDWD +: PSUMDWD]
//   i_psconf_PS       config word: [SHW+1]=last, [SHW]=relu, [SHW-1:0]=shamt
//   i_flush           synchronous drop of all buffered data
//   o_OUT_rdy/i_OUT_ack output element handshake
//   o_OUT_data        post-processed element (unsigned if relu, else signed)
//   o_OUT_idx         element index within its vector
//   o_OUT_last        last element of a vector flagged last
//   o_busy            buffer non-empty
module psum_out_stage #(
    parameter int PEROW   = 4,
    parameter int PSUMDWD = 16,
    parameter int OUTDW   = 8,
    parameter int SHW     = 4,
    localparam int IDXW   = $clog2(PEROW),
    localparam int CFGW   = SHW + 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_PS_rdy,
    output logic                     o_PS_ack,
    input  logic [PEROW*PSUMDWD-1:0] i_Psum_PS,
    input  logic [CFGW-1:0]          i_psconf_PS,
    input  logic                     i_flush,
    output logic                     o_OUT_rdy,
    input  logic                     i_OUT_ack,
    output logic [OUTDW-1:0]         o_OUT_data,
    output logic [IDXW-1:0]          o_OUT_idx,
    output logic                     o_OUT_last,
    output logic                     o_busy
);

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(PEROW - 1);
    // Saturation bounds at the PSUMDWD+1 working width.
    localparam logic signed [PSUMDWD:0] SAT_UMAX = (PSUMDWD+1)'((1 << OUTDW) - 1);
    localparam logic signed [PSUMDWD:0] SAT_SMAX = (PSUMDWD+1)'((1 << (OUTDW - 1)) - 1);
    localparam logic signed [PSUMDWD:0] SAT_SMIN = (PSUMDWD+1)'(-(1 << (OUTDW - 1)));

    function automatic logic [OUTDW-1:0] post_proc(
        input logic [PSUMDWD-1:0] x,
        input logic [SHW-1:0]     sh,
        input logic               relu
    );
        logic signed [PSUMDWD:0] ext, rnd, y;
        // One extra bit keeps the rounding add from overflowing.
        ext = $signed({x[PSUMDWD-1], x});
        rnd = '0;
        if (sh == '0) begin
            y = ext;
        end else begin
            rnd = {{PSUMDWD{1'b0}}, 1'b1} << (sh - 1'b1);
            y   = (ext + rnd) >>> sh;
        end
        if (relu) begin
            if (y < 0)             y = '0;
            else if (y > SAT_UMAX) y = SAT_UMAX;
        end else begin
            if (y > SAT_SMAX)      y = SAT_SMAX;
            else if (y < SAT_SMIN) y = SAT_SMIN;
        end
        return y[OUTDW-1:0];
    endfunction

    logic [1:0][PEROW-1:0][PSUMDWD-1:0] mem_q, mem_d;
    logic [1:0][CFGW-1:0]               cfg_q, cfg_d;
    logic                               wr_ptr_q, wr_ptr_d;
    logic                               rd_ptr_q, rd_ptr_d;
    logic [1:0]                         count_q, count_d;
    logic [IDXW-1:0]                    idx_q, idx_d;
    logic [OUTDW-1:0]                   data_q, data_d;
    logic                               last_q, last_d;
    logic [CFGW-1:0]                    sel_cfg;
    logic                               push, out_xfer, pop;

    assign o_PS_ack  = (count_q < 2'd2) && !i_flush;
    assign o_OUT_rdy = (count_q != 2'd0);
    assign o_busy    = (count_q != 2'd0);
    assign o_OUT_data = data_q;
    assign o_OUT_idx  = idx_q;
    assign o_OUT_last = last_q;

    assign push     = i_PS_rdy && o_PS_ack;
    assign out_xfer = o_OUT_rdy && i_OUT_ack;
    assign pop      = out_xfer && (idx_q == IDX_LAST);

    always_comb begin
        mem_d    = mem_q;
        cfg_d    = cfg_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = i_Psum_PS;
            cfg_d[wr_ptr_q] = i_psconf_PS;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            idx_d    = '0;
        end else if (out_xfer) begin
            idx_d = idx_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (i_flush) begin
            count_d  = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            idx_d    = '0;
        end

        // Outputs are computed from the next-state view so the element is
        // already registered the cycle o_OUT_rdy rises (covers the push into
        // an empty buffer: the new vector is visible through mem_d).
        sel_cfg = cfg_d[rd_ptr_d];
        data_d  = '0;
        last_d  = 1'b0;
        if (count_d != 2'd0) begin
            data_d = post_proc(mem_d[rd_ptr_d][idx_d], sel_cfg[SHW-1:0], sel_cfg[SHW]);
            last_d = sel_cfg[SHW+1] && (idx_d == IDX_LAST);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_q    <= '0;
            cfg_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            cfg_q    <= cfg_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: doc/psum_out_stage.md
Name: psum_out_stage

Overview:
- Sits directly downstream of the path stage and consumes its POUT stream: one vector of PEROW partial sums plus its PSconf per transfer.
- Buffers up to two vectors, then post-processes each element: arithmetic right shift with round-half-up, optional ReLU, saturation to OUTDW.
- Serializes the result one element per transfer onto the output-buffer write bus.
- Frees the path stage from output back-pressure of the narrower output bus.

Parameters:
- PEROW, 4, psum elements per input vector.
- PSUMDWD, 16, psum element width (two's complement).
- OUTDW, 8, output element width.
- SHW, 4, width of the shift-amount field.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_PS_rdy  input  1  input vector valid (rdy/ack handshake).
- o_PS_ack  output  1  input vector accepted.
- i_Psum_PS  input  PEROW x PSUMDWD  psum vector.
- i_psconf_PS  input  PSconf  per-vector config. Fields used: relu (1b), shamt (SHW b), last (1b).
- i_flush  input  1  synchronous drop of all buffered data.
- o_OUT_rdy  output  1  output element valid.
- i_OUT_ack  input  1  output element accepted.
- o_OUT_data  output  OUTDW  post-processed element.
- o_OUT_idx  output  log2(PEROW)  element index within its vector.
- o_OUT_last  output  1  final element of a vector whose psconf.last is 1.
- o_busy  output  1  buffer non-empty.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous, active-high.
- Reset values: o_OUT_rdy=0, o_OUT_data=0, o_OUT_idx=0, o_OUT_last=0, o_busy=0. Buffer count=0, element index=0, rd/wr pointers=0.
- Handshake rules (both sides):
  - Transfer occurs when rdy && ack in the same cycle.
  - A source holds rdy and data stable until ack.
  - The stage never retracts o_OUT_rdy before i_OUT_ack.
- Input side:
  - o_PS_ack = (count < 2), combinational from registered count only. No same-cycle bypass when full.
  - On transfer, vector and psconf are written at wr_ptr, and wr_ptr toggles.
- Buffer: 2 entries, count 0..2.
  - Push and pop in the same cycle leave count unchanged.
  - Pop happens on the output transfer of the element with idx==PEROW-1.
- Output serializer:
  - Element index counter runs 0..PEROW-1. It advances on each output transfer and wraps to 0 on the pop.
  - o_OUT_rdy = (count > 0).
  - o_OUT_data, o_OUT_idx and o_OUT_last are registered, computed from entry rd_ptr at the next index. They update on the cycle after a transfer or push so they are valid whenever o_OUT_rdy=1.
- Latency: a vector accepted in cycle t presents element 0 with o_OUT_rdy=1 in cycle t+1.
- Throughput: one element per cycle when i_OUT_ack is held high, i.e. one vector per PEROW cycles with no bubbles between vectors.
- Arithmetic per element x (signed PSUMDWD):
  - shamt==0: y = x.
  - shamt>0: y = (x + (1 << (shamt-1))) >>> shamt. The add is performed at PSUMDWD+1 bits, so there is no overflow.
  - relu=1: y<0 becomes 0, then y saturates to [0, 2^OUTDW - 1] and is output unsigned.
  - relu=0: y saturates to [-2^(OUTDW-1), 2^(OUTDW-1) - 1] and is output two's complement.
- o_OUT_last = psconf.last && (idx == PEROW-1).
- i_flush (priority over push and pop in the same cycle):
  - Next cycle: count=0, pointers=0, idx=0, o_OUT_rdy=0.
  - o_PS_ack is forced to 0 during the flush cycle.
- Reset mid-operation: all state returns to reset values immediately; any in-flight vector is lost.
- i_OUT_ack while o_OUT_rdy=0: ignored.

Test Plan:
- Single vector {100, -100, 7, -8}, shamt=2, relu=0, i_OUT_ack=1 → over 4 consecutive cycles starting t+1, data {25, -25, 2, -2}, idx 0..3, o_busy falls after the 4th.
- Same vector with relu=1, last=1 → data {25, 0, 2, 0}; o_OUT_last=1 only with idx=3.
- Saturation: x=3000, shamt=0, relu=0 → data 127 (0x7F); x=-3000 → -128 (0x80); x=3000 with relu=1 → 255.
- Back-pressure: i_OUT_ack=0, three vectors offered back-to-back → first two acked in consecutive cycles, third held with o_PS_ack=0. After 4 output transfers the third is acked in the cycle following the pop, and output order is preserved.
- Streaming: 8 vectors, i_PS_rdy and i_OUT_ack always 1 → 32 output transfers in 32 consecutive cycles with no gap.
- i_flush asserted with count=2 and idx=2 while i_PS_rdy=1 → no ack that cycle, o_OUT_rdy=0 next cycle. The next vector's element 0 appears with idx=0. Async i_rst pulse mid-vector gives the same result without a clock edge.
